feature_serializer: RTL and testbench

//  Upstream feeder for the decision-tree classifier core. Accepts one parallel

---
 rtl/feature_serializer.sv | 123 ++++++++++++
 tb/tb_feature_serializer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feature_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | feature_serializer: buffers parallel feature vectors and streams them one  |
// | feature per transfer. Optional macro FSER_DROP_EN: drop-on-full + counter. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module feature_serializer #(
  parameter int FEATURES      = 3,
  parameter int IN_WIDTH      = 10,
  parameter int DEPTH         = 2,
  parameter int CHANNEL_COUNT = 1,
  localparam int CW = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
  localparam int FW = (FEATURES > 1) ? $clog2(FEATURES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         vec_valid,
  output logic                         vec_ready,
  input  logic [FEATURES*IN_WIDTH-1:0] vec_data,
  input  logic [CW-1:0]                vec_channel,
  output logic                         out_valid,
  input  logic                         core_ready,
  output logic [IN_WIDTH-1:0]          sample,
  output logic [FW-1:0]                feature_index,
  output logic [CW-1:0]                out_channel,
  output logic                         last
`ifdef FSER_DROP_EN
  ,
  output logic [15:0]                  drop_count
`endif
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_vec_w = FEATURES * IN_WIDTH;

  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
  localparam logic [FW-1:0]      c_last_idx = FW'(FEATURES - 1);

  // Each entry holds {channel, vector}; channel sits above the feature data.
  logic [CW+c_vec_w-1:0] r_mem [DEPTH];

  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [FW-1:0]      r_fidx;

  logic                  w_full;
  logic                  w_xfer;
  logic                  w_pop;
  logic                  w_push;
  logic [CW+c_vec_w-1:0] w_head;

  assign w_full    = (r_count == c_depth);
  assign out_valid = (r_count != '0);
  assign w_xfer    = out_valid & core_ready;
  assign w_pop     = w_xfer & (r_fidx == c_last_idx);

`ifdef FSER_DROP_EN
  logic        w_drop;
  logic [15:0] r_drop_count;

  // A pop on the same edge frees the slot, so a full buffer still accepts.
  assign vec_ready  = 1'b1;
  assign w_push     = vec_valid & (~w_full | w_pop);
  assign w_drop     = vec_valid & w_full & ~w_pop;
  assign drop_count = r_drop_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end
`else
  // Ready looks at occupancy only; a same-cycle pop does not open the door.
  assign vec_ready = (r_count < c_depth);
  assign w_push    = vec_valid & vec_ready;
`endif

  assign w_head        = r_mem[r_rd_ptr];
  assign sample        = out_valid ? w_head[r_fidx*IN_WIDTH +: IN_WIDTH] : '0;
  assign out_channel   = out_valid ? w_head[c_vec_w +: CW] : '0;
  assign feature_index = r_fidx;
  assign last          = (r_fidx == c_last_idx);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {vec_channel, vec_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fidx   <= '0;
    end else begin
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end

      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      end

      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      end

      if (w_xfer) begin
        r_fidx <= w_pop ? '0 : r_fidx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_feature_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_feature_serializer: self-checking bench for feature_serializer.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_feature_serializer;

  localparam int FEATURES = 3;
  localparam int IN_WIDTH = 10;
  localparam int DEPTH    = 2;
  localparam int VW       = FEATURES * IN_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            vec_valid;
  logic            vec_ready;
  logic [VW-1:0]   vec_data;
  logic [0:0]      vec_channel;
  logic            out_valid;
  logic            core_ready;
  logic [IN_WIDTH-1:0] sample;
  logic [1:0]      feature_index;
  logic [0:0]      out_channel;
  logic            last;

  logic            vv3, vr3, ov3, cr3, l3;
  logic [VW-1:0]   vd3;
  logic [1:0]      vc3, oc3, fi3;
  logic [IN_WIDTH-1:0] s3;

`ifdef FSER_DROP_EN
  logic [15:0] drop_count;
  logic [15:0] drop_count3;
`endif

  feature_serializer #(
    .FEATURES(FEATURES), .IN_WIDTH(IN_WIDTH), .DEPTH(DEPTH), .CHANNEL_COUNT(1)
  ) u_dut (
    .clk(clk), .reset(reset),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .vec_channel(vec_channel), .out_valid(out_valid), .core_ready(core_ready),
    .sample(sample), .feature_index(feature_index), .out_channel(out_channel),
    .last(last)
`ifdef FSER_DROP_EN
    , .drop_count(drop_count)
`endif
  );

  feature_serializer #(
    .FEATURES(FEATURES), .IN_WIDTH(IN_WIDTH), .DEPTH(3), .CHANNEL_COUNT(4)
  ) u_dut3 (
    .clk(clk), .reset(reset),
    .vec_valid(vv3), .vec_ready(vr3), .vec_data(vd3),
    .vec_channel(vc3), .out_valid(ov3), .core_ready(cr3),
    .sample(s3), .feature_index(fi3), .out_channel(oc3),
    .last(l3)
`ifdef FSER_DROP_EN
    , .drop_count(drop_count3)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of buffered vectors plus the feature cursor of the head.
  typedef struct packed {
    logic [0:0]    ch;
    logic [VW-1:0] d;
  } vec_t;

  vec_t mq[$];
  int   mfi;
  int   mdrop;

  task automatic do_reset();
    reset = 1'b0;
    vec_valid = 1'b0; core_ready = 1'b0; vec_data = '0; vec_channel = '0;
    mq.delete(); mfi = 0; mdrop = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus on u_dut, checked against the queue model; entered at posedge+1.
  task automatic cyc(input logic vv, input logic [VW-1:0] d, input logic [0:0] ch, input logic cr);
    bit   pop, ok;
    vec_t h;
    vec_valid = vv; vec_data = d; vec_channel = ch; core_ready = cr;
    #1;
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
`ifdef FSER_DROP_EN
    chk("vec_ready", 32'(vec_ready), 32'd1);
    chk("drop_count", 32'(drop_count), 32'(mdrop));
`else
    chk("vec_ready", 32'(vec_ready), 32'(mq.size() < DEPTH));
`endif
    chk("feature_index", 32'(feature_index), 32'(mfi));
    chk("last", 32'(last), 32'(mfi == FEATURES - 1));
    pop = 1'b0;
    if (mq.size() != 0) begin
      h = mq[0];
      chk("sample", 32'(sample), 32'(h.d[mfi*IN_WIDTH +: IN_WIDTH]));
      chk("out_channel", 32'(out_channel), 32'(h.ch));
      if (cr) begin
        if (mfi == FEATURES - 1) begin
          pop = 1'b1;
          mfi = 0;
        end else begin
          mfi++;
        end
      end
    end
    ok = (mq.size() < DEPTH);
`ifdef FSER_DROP_EN
    ok = ok || pop;
`endif
    if (pop) void'(mq.pop_front());
    if (vv) begin
      if (ok) mq.push_back('{ch: ch, d: d});
`ifdef FSER_DROP_EN
      else if (mdrop < 65535) mdrop++;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic                vv;
    logic [VW-1:0]       d;
    logic                cr;
    logic                ov;
    logic                vr;
    logic [IN_WIDTH-1:0] s;
    int                  idx;
    logic                lst;
  } row_t;

  row_t tbl[12];

  logic [VW-1:0] sd[10];
  logic [1:0]    sc[10];

  initial begin
    vv3 = 1'b0; cr3 = 1'b0; vd3 = '0; vc3 = '0;
    do_reset();

    // Reset state, sampled again while reset is held.
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_vec_ready", 32'(vec_ready), 32'd1);
    chk("rst_feature_index", 32'(feature_index), 32'd0);
    chk("rst_last", 32'(last), 32'd0);
`ifdef FSER_DROP_EN
    chk("rst_drop_count", 32'(drop_count), 32'd0);
`endif
    do_reset();

    // Single vector {30,-2,5} at full rate, then core_ready pattern 1,0,0,1,1.
    tbl[0]  = '{1'b1, {10'd30, 10'h3FE, 10'd5},     1'b1, 1'b0, 1'b1, 10'd0,   0, 1'b0};
    tbl[1]  = '{1'b0, '0,                           1'b1, 1'b1, 1'b1, 10'd5,   0, 1'b0};
    tbl[2]  = '{1'b0, '0,                           1'b1, 1'b1, 1'b1, 10'h3FE, 1, 1'b0};
    tbl[3]  = '{1'b0, '0,                           1'b1, 1'b1, 1'b1, 10'd30,  2, 1'b1};
    tbl[4]  = '{1'b0, '0,                           1'b1, 1'b0, 1'b1, 10'd0,   0, 1'b0};
    tbl[5]  = '{1'b1, {10'd100, 10'h39C, 10'h200},  1'b0, 1'b0, 1'b1, 10'd0,   0, 1'b0};
    tbl[6]  = '{1'b0, '0,                           1'b1, 1'b1, 1'b1, 10'h200, 0, 1'b0};
    tbl[7]  = '{1'b0, '0,                           1'b0, 1'b1, 1'b1, 10'h39C, 1, 1'b0};
    tbl[8]  = '{1'b0, '0,                           1'b0, 1'b1, 1'b1, 10'h39C, 1, 1'b0};
    tbl[9]  = '{1'b0, '0,                           1'b1, 1'b1, 1'b1, 10'h39C, 1, 1'b0};
    tbl[10] = '{1'b0, '0,                           1'b1, 1'b1, 1'b1, 10'd100, 2, 1'b1};
    tbl[11] = '{1'b0, '0,                           1'b1, 1'b0, 1'b1, 10'd0,   0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      vec_valid = tbl[i].vv; vec_data = tbl[i].d; vec_channel = '0; core_ready = tbl[i].cr;
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_vec_ready", i), 32'(vec_ready), 32'(tbl[i].vr));
      chk($sformatf("tbl%0d_index", i), 32'(feature_index), 32'(tbl[i].idx));
      chk($sformatf("tbl%0d_last", i), 32'(last), 32'(tbl[i].lst));
      if (tbl[i].ov) chk($sformatf("tbl%0d_sample", i), 32'(sample), 32'(tbl[i].s));
      @(posedge clk);
      #1;
    end
    vec_valid = 1'b0;

    // Backpressure: two vectors fill the buffer, third waits for the first pop.
    cyc(1'b1, {10'd1, 10'd2, 10'd3}, 1'b0, 1'b0);
    cyc(1'b1, {10'd4, 10'd5, 10'd6}, 1'b1, 1'b0);
`ifndef FSER_DROP_EN
    chk("t2_full_ready", 32'(vec_ready), 32'd0);
`endif
    for (int i = 0; i < 4; i++) cyc(1'b1, {10'd7, 10'd8, 10'd9}, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0, 1'b1);

    // Reset asserted mid-vector, after index 1 has transferred.
    cyc(1'b1, {10'd11, 10'd12, 10'd13}, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_vec_ready", 32'(vec_ready), 32'd1);
    chk("t5_index", 32'(feature_index), 32'd0);
    mq.delete(); mfi = 0; mdrop = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, {10'd21, 10'd22, 10'd23}, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b1);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), VW'($urandom), 1'($urandom), 1'($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0, 1'b1);

    // Continuous stream of 10 vectors through the DEPTH=3 instance.
    begin
      int occ, sent, got, first, lastc, k, j;
      bit pop, acc;
      for (int i = 0; i < 10; i++) begin
        sd[i] = VW'($urandom);
        sc[i] = 2'($urandom_range(0, 3));
      end
      occ = 0; sent = 0; got = 0; first = -1; lastc = -1;
      for (int c = 0; c < 200 && got < 30; c++) begin
        k = got % 3;
        j = got / 3;
        pop = (occ > 0) && (k == 2);
        acc = (sent < 10) && (occ < 3);
`ifdef FSER_DROP_EN
        acc = (sent < 10) && ((occ < 3) || pop);
`endif
        vv3 = acc; vd3 = sd[sent % 10]; vc3 = sc[sent % 10]; cr3 = 1'b1;
        #1;
        chk("t4_out_valid", 32'(ov3), 32'(occ > 0));
`ifndef FSER_DROP_EN
        chk("t4_vec_ready", 32'(vr3), 32'(occ < 3));
`endif
        if (occ > 0) begin
          chk("t4_sample", 32'(s3), 32'(sd[j][k*IN_WIDTH +: IN_WIDTH]));
          chk("t4_index", 32'(fi3), 32'(k));
          chk("t4_channel", 32'(oc3), 32'(sc[j]));
          chk("t4_last", 32'(l3), 32'(k == 2));
          if (first < 0) first = c;
          lastc = c;
          got++;
        end
        if (pop) occ--;
        if (acc) begin
          occ++;
          sent++;
        end
        @(posedge clk);
        #1;
      end
      vv3 = 1'b0; cr3 = 1'b0;
      chk("t4_transfers", 32'(got), 32'd30);
      chk("t4_span_cycles", 32'(lastc - first + 1), 32'd30);
    end

`ifdef FSER_DROP_EN
    // Drop mode: five offers into a stalled DEPTH=2 buffer.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, {10'(i), 10'(i + 40), 10'(i + 80)}, 1'b0, 1'b0);
    chk("t6_drop_count", 32'(drop_count), 32'd3);
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
